// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit positions and engine state shared by
// the UART register file and its serial engines.
package uart_pkg;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int CTRL_TX_GO = 7;
    localparam int CTRL_RX_EN = 6;

    localparam int ST_TX_BUSY   = 7;
    localparam int ST_RX_VALID  = 6;
    localparam int ST_OVERRUN   = 5;
    localparam int ST_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchroniser, start validation
// at mid-start, mid-bit data sampling and stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              en,
    input  logic              rx,
    output logic              done,
    output logic              ferr,
    output logic [DATA_W-1:0] data
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);

    logic              s1, s2, s_prev;
    state_t            st, st_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     bit_q, bit_n;
    logic [DATA_W-1:0] sh, sh_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
            st     <= IDLE;
            cnt    <= '0;
            bit_q  <= '0;
            sh     <= '0;
        end else begin
            s1     <= rx;
            s2     <= s1;
            s_prev <= s2;
            st     <= st_n;
            cnt    <= cnt_n;
            bit_q  <= bit_n;
            sh     <= sh_n;
        end
    end

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        bit_n = bit_q;
        sh_n  = sh;
        done  = 1'b0;
        ferr  = 1'b0;
        if (!en) begin
            st_n = IDLE;
        end else begin
            case (st)
                IDLE: begin
                    if (s_prev && !s2) begin
                        st_n  = START;
                        cnt_n = '0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt_n = cnt + 1'b1;
                        // mid-start re-check rejects short glitches
                        if (cnt == HALF) begin
                            cnt_n = '0;
                            bit_n = '0;
                            st_n  = s2 ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt_n = '0;
                            sh_n  = {s2, sh[DATA_W-1:1]};
                            bit_n = bit_q + 1'b1;
                            if (bit_q == BW'(DATA_W - 1))
                                st_n = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick && cnt == LAST) begin
                        st_n = IDLE;
                        done = s2;
                        ferr = !s2;
                    end else if (tick) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: st_n = IDLE;
            endcase
        end
    end

    assign data = sh;

endmodule

// File: rtl/uart_top.sv
// uart_top: memory-mapped 8N1 UART; register file, baud tick and TX
// engine live here, the receiver is uart_rx.
module uart_top
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int RESET_DIV = 130
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic              we,
    input  logic              re,
    output logic              tx,
    input  logic              rx
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    logic [DATA_W-1:0] div_q, baud_cnt, txdata, rxdata, rd_mux;
    logic              tx_go, rx_en, rx_valid, overrun, frame_err;
    logic              tick, tx_launch, tx_busy;
    logic              rx_done, rx_ferr;
    logic [DATA_W-1:0] rx_byte;

    state_t            tx_st, tx_st_n;
    logic [CW-1:0]     tx_cnt, tx_cnt_n;
    logic [BW-1:0]     tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;

    assign tick    = (baud_cnt == div_q);
    assign tx_busy = (tx_st != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            baud_cnt <= '0;
        else if ((we && address == ADDR_DIV) || tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DIV:  rd_mux = div_q;
            ADDR_CTRL: begin
                rd_mux[CTRL_TX_GO] = tx_go;
                rd_mux[CTRL_RX_EN] = rx_en;
            end
            ADDR_DATA: rd_mux = rxdata;
            ADDR_STAT: begin
                rd_mux[ST_TX_BUSY]   = tx_busy;
                rd_mux[ST_RX_VALID]  = rx_valid;
                rd_mux[ST_OVERRUN]   = overrun;
                rd_mux[ST_FRAME_ERR] = frame_err;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= DATA_W'(RESET_DIV);
            tx_go     <= 1'b0;
            rx_en     <= 1'b0;
            txdata    <= '0;
            rxdata    <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            read_data <= '0;
        end else begin
            if (tx_launch)
                tx_go <= 1'b0;
            if (re && address == ADDR_DATA)
                rx_valid <= 1'b0;
            if (we) begin
                case (address)
                    ADDR_DIV:  div_q <= write_data;
                    ADDR_CTRL: begin
                        tx_go <= write_data[CTRL_TX_GO];
                        rx_en <= write_data[CTRL_RX_EN];
                    end
                    ADDR_DATA: txdata <= write_data;
                    ADDR_STAT: begin
                        if (write_data[ST_RX_VALID])  rx_valid  <= 1'b0;
                        if (write_data[ST_OVERRUN])   overrun   <= 1'b0;
                        if (write_data[ST_FRAME_ERR]) frame_err <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // new-byte events come last so set beats any clear
            if (rx_done) begin
                rxdata   <= rx_byte;
                rx_valid <= 1'b1;
                if (rx_valid) overrun <= 1'b1;
            end
            if (rx_ferr)
                frame_err <= 1'b1;
            if (re)
                read_data <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st  <= IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
        end else begin
            tx_st  <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_bit <= tx_bit_n;
            tx_sh  <= tx_sh_n;
        end
    end

    always_comb begin
        tx_st_n   = tx_st;
        tx_cnt_n  = tx_cnt;
        tx_bit_n  = tx_bit;
        tx_sh_n   = tx_sh;
        tx_launch = 1'b0;
        case (tx_st)
            IDLE: begin
                if (tx_go) begin
                    tx_launch = 1'b1;
                    tx_st_n   = START;
                    tx_cnt_n  = '0;
                    tx_sh_n   = txdata;
                end
            end
            START: begin
                if (tick) begin
                    tx_cnt_n = tx_cnt + 1'b1;
                    if (tx_cnt == LAST) begin
                        tx_cnt_n = '0;
                        tx_bit_n = '0;
                        tx_st_n  = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tx_cnt_n = tx_cnt + 1'b1;
                    if (tx_cnt == LAST) begin
                        tx_cnt_n = '0;
                        tx_sh_n  = tx_sh >> 1;
                        tx_bit_n = tx_bit + 1'b1;
                        if (tx_bit == BW'(DATA_W - 1))
                            tx_st_n = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tx_cnt_n = tx_cnt + 1'b1;
                    if (tx_cnt == LAST) begin
                        tx_cnt_n = '0;
                        tx_st_n  = IDLE;
                    end
                end
            end
            default: tx_st_n = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        if (tx_st == START)
            tx = 1'b0;
        else if (tx_st == DATA)
            tx = tx_sh[0];
    end

    uart_rx #(
        .DATA_W (DATA_W),
        .OVS    (OVS)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .en   (rx_en),
        .rx   (rx),
        .done (rx_done),
        .ferr (rx_ferr),
        .data (rx_byte)
    );

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized bench for uart_top against a register-level
// model of the UART's visible state and frame timing.
module tb_uart_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] address = 2'd0;
    logic [7:0] write_data = 8'd0;
    logic [7:0] read_data;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       tx;
    logic       rx;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_top dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .we         (we),
        .re         (re),
        .tx         (tx),
        .rx         (rx)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] m_div = 8'd130;
    logic [7:0] m_rxdata = 8'd0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_rxen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {1'b0, m_valid, m_ovr, m_ferr, 4'b0};
    endfunction

    function automatic int bit_clks();
        return (int'(m_div) + 1) * 16;
    endfunction

    task automatic m_good(input logic [7:0] b);
        if (m_valid) m_ovr = 1'b1;
        m_valid  = 1'b1;
        m_rxdata = b;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; write_data = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        if (a == 2'd0) m_div = d;
        if (a == 2'd1) m_rxen = d[6];
        if (a == 2'd3) begin
            if (d[6]) m_valid = 1'b0;
            if (d[5]) m_ovr = 1'b0;
            if (d[4]) m_ferr = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = read_data;
        if (a == 2'd2) m_valid = 1'b0;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop_ok);
        int bt;
        bt = bit_clks();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bt) @(negedge clk);
        end
        rx_drv = stop_ok;
        repeat (bt) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bt) @(negedge clk);
        if (m_rxen) begin
            if (stop_ok) m_good(b);
            else m_ferr = 1'b1;
        end
    endtask

    initial begin
        repeat (90000) @(negedge clk);
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d, a, b, exp_byte;
        int n, t0, len, bt;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_read_data", read_data, 0);
        rst = 1'b1;
        bus_read(2'd0, d); check("rst_div", d, 130);
        bus_read(2'd1, d); check("rst_ctrl", d, 0);
        bus_read(2'd3, d); check("rst_stat", d, 0);

        bus_write(2'd3, 8'hB4);
        bus_read(2'd3, d); check("w1c_nop", d, m_status());

        // full-rate TX frame at reset divisor
        exp_byte = 8'h69;
        bus_write(2'd2, exp_byte);
        bus_write(2'd1, 8'h80);
        n = 0;
        while (tx !== 1'b0 && n < 5000) begin
            @(negedge clk); n++;
        end
        check("tx_start_seen", n < 5000, 1);
        t0 = cyc;
        bus_read(2'd1, d); check("tx_ctrl_cleared", d, 8'h00);
        bus_read(2'd3, d); check("tx_busy_start", d, 8'h80);
        n = 0;
        while (tx === 1'b0 && n < 3000) begin
            @(negedge clk); n++;
        end
        len = cyc - t0;
        check("tx_start_len", (len >= 1960 && len <= 2100), 1);
        repeat (1048) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_bit%0d", i), tx, exp_byte[i]);
            if (i == 0) begin
                bus_read(2'd3, d); check("tx_busy_data", d, 8'h80);
                repeat (2092) @(negedge clk);
            end else begin
                repeat (2096) @(negedge clk);
            end
        end
        check("tx_stop", tx, 1);
        bus_read(2'd3, d); check("tx_busy_stop", d, 8'h80);
        repeat (1200) @(negedge clk);
        bus_read(2'd3, d); check("tx_idle_stat", d, 8'h00);

        bus_write(2'd0, 8'h10);
        bus_read(2'd0, d); check("div_rw", d, 8'h10);
        bus_write(2'd0, 8'h03);
        bus_read(2'd0, d); check("div_rw3", d, m_div);
        bt = bit_clks();

        // loopback frames
        loop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'h69 : 8'($urandom);
            bus_write(2'd2, b);
            bus_write(2'd1, 8'hC0);
            repeat (12 * bt) @(negedge clk);
            m_good(b);
            bus_read(2'd3, d); check("lb_stat", d, m_status());
            bus_read(2'd2, d); check("lb_data", d, b);
            bus_read(2'd3, d); check("lb_stat_clr", d, m_status());
        end

        // pending TX_GO and mid-frame TXDATA write
        a = 8'($urandom);
        b = ~a;
        bus_write(2'd2, a);
        bus_write(2'd1, 8'hC0);
        repeat (bt) @(negedge clk);
        bus_read(2'd3, d); check("pend_busy", d, 8'h80 | m_status());
        bus_write(2'd2, b);
        bus_write(2'd1, 8'hC0);
        bus_read(2'd1, d); check("pend_ctrl", d, 8'hC0);
        repeat (10 * bt) @(negedge clk);
        m_good(a);
        bus_read(2'd2, d); check("pend_first", d, a);
        repeat (11 * bt) @(negedge clk);
        m_good(b);
        bus_read(2'd3, d); check("pend_stat", d, m_status());
        bus_read(2'd2, d); check("pend_second", d, b);
        loop = 1'b0;

        // directed overrun and framing error
        send_serial(8'h5A, 1'b1);
        send_serial(8'hA5, 1'b1);
        send_serial(8'h3C, 1'b0);
        bus_read(2'd3, d); check("err_stat", d, 8'h70);
        bus_read(2'd2, d); check("err_data_kept", d, 8'hA5);
        bus_write(2'd3, 8'h30);
        bus_read(2'd3, d); check("err_clear", d, 8'h00);

        // random frames with random stop bits and reads
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            send_serial(b, $urandom_range(3) != 0);
            bus_read(2'd3, d); check("rand_stat", d, m_status());
            if ($urandom_range(1) == 1) begin
                exp_byte = m_rxdata;
                bus_read(2'd2, d); check("rand_data", d, exp_byte);
            end
        end
        bus_write(2'd3, 8'h70);
        bus_read(2'd3, d); check("rand_clear", d, m_status());

        // glitch rejected
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * bt) @(negedge clk);
        bus_read(2'd3, d); check("glitch_stat", d, m_status());

        // receiver disabled ignores a frame
        bus_write(2'd1, 8'h00);
        send_serial(8'h81, 1'b1);
        bus_read(2'd3, d); check("rxdis_stat", d, m_status());

        // async reset in the middle of a frame
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h80);
        n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk); n++;
        end
        repeat (3 * bt) @(negedge clk);
        check("abort_mid_low", tx, 0);
        rst = 1'b0;
        #1;
        check("abort_tx_high", tx, 1);
        m_div = 8'd130; m_rxdata = 8'd0; m_valid = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_rxen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_read(2'd3, d); check("abort_stat", d, m_status());
        bus_read(2'd0, d); check("abort_div", d, m_div);
        repeat (300) @(negedge clk);
        check("abort_idle", tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
